branch_resolver: RTL
====================

# branch_resolver

Resolution-side partner of the branch predictor. Captures each issued prediction in an in-order queue, matches it against the resolved branch outcome, and drives the predictor's `taken` update. Flags mispredictions, flushes wrong-path predictions, and keeps saturating accuracy counters. Sits between the predictor output and the execute-stage branch unit.

## Interface

Parameters:
- `DEPTH`, 4: maximum outstanding (unresolved) predictions; power of two, ≥2.
- `FLUSH_CYCLES`, 2: cycles the block stays in FLUSH after a mispredict; ≥1.
- `CNT_W`, 16: width of the accuracy counters.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `pred_valid`, in, 1: a prediction is being issued this cycle.
- `pred_taken`, in, 1: the issued prediction (1 = taken).
- `pred_ready`, out, 1: the queue can accept a prediction this cycle (combinational).
- `res_valid`, in, 1: an outcome for the oldest outstanding branch is presented.
- `res_taken`, in, 1: the actual outcome.
- `upd_valid`, out, 1: registered; the update to the predictor is valid.
- `upd_taken`, out, 1: registered; drives the predictor's `taken` input.
- `mispredict`, out, 1: registered; one-cycle pulse per wrong prediction.
- `flush`, out, 1: high while in FLUSH.
- `err_unmatched`, out, 1: registered; one-cycle pulse when a resolution arrives with no queued prediction.
- `pending`, out, $clog2(DEPTH+1): number of queued predictions.
- `total_cnt`, out, CNT_W: resolved branches, saturating.
- `miss_cnt`, out, CNT_W: mispredictions, saturating.

## Operation

- State machine has two states: RUN and FLUSH.
  - After reset: RUN.
  - RUN → FLUSH on a mispredicting pop.
  - FLUSH → RUN after FLUSH_CYCLES cycles, tracked by a down-counter.
- `pred_ready` = `!rst && state==RUN && pending<DEPTH`.
- Push: `pred_valid && pred_ready` writes `pred_taken` at the tail.
- Pop: `res_valid && pending>0` removes the head. The popped entry is compared with `res_taken`.
  - In the next cycle: `upd_valid=1`, `upd_taken=res_taken`, `mispredict = (head != res_taken)`.
  - `total_cnt` increments; `miss_cnt` also increments on a mispredict.
  - Both counters saturate at all-ones and never wrap.
- Mispredicting pop:
  - Every remaining entry is discarded; `pending` becomes 0 next cycle.
  - A push in the same cycle is discarded as wrong-path.
  - The state enters FLUSH.
- Correct pop with a simultaneous push: both take effect and `pending` is unchanged.
- Full queue with a simultaneous pop: the push is rejected because `pred_ready` was 0. The pop proceeds.
- `res_valid` with `pending==0`, including any cycle in FLUSH:
  - No pop and no counter change.
  - `upd_valid` stays 0.
  - `err_unmatched` pulses the next cycle.
- Pointers wrap modulo DEPTH. Occupancy is tracked by `pending`, so full and empty are unambiguous.

## Timing

- Reset values, taking effect on the first edge with `rst=1`:
  - state=RUN, queue empty, `pending=0`.
  - `upd_valid`, `upd_taken`, `mispredict`, `flush`, `err_unmatched` all 0.
  - `total_cnt`, `miss_cnt` both 0.
  - `pred_ready` is 0 while `rst` is high.
- Reset asserted mid-FLUSH or with the queue non-empty: all of the above are forced on that edge, and any in-flight `upd_valid` is dropped.
- Pop-to-update latency is 1 cycle, and `upd_valid` is high for exactly 1 cycle per pop. Back-to-back pops give back-to-back updates.
- Push-to-pending latency is 1 cycle. A pushed entry can be popped from the following cycle onward, never in the same cycle.
- `flush` rises in the same cycle as `mispredict` and stays high for FLUSH_CYCLES cycles. `pred_ready` is 0 for those cycles and becomes 1 on the first RUN cycle.
- A mispredict detected exactly as FLUSH would end cannot occur, because the queue is empty during FLUSH.

## Test plan

- Reset, then push T,N,T (one per cycle), then resolve T,N,T:
  - `pending` goes 1,2,3,2,1,0.
  - `upd_valid` is high for 3 cycles with `upd_taken` = 1,0,1.
  - `mispredict` stays 0; `total_cnt=3`, `miss_cnt=0`.
- DEPTH=4: push 5 predictions continuously:
  - `pred_ready` drops after the 4th push, and the 5th is held off.
  - Resolve one while `pred_valid` stays high: the 5th is accepted 1 cycle after the pop.
- Push T,T,T, then resolve N:
  - `mispredict` pulses; `pending` goes 3→0.
  - `flush` is high for 2 cycles, with `pred_ready=0` for exactly those cycles.
  - A push during them is ignored; `miss_cnt=1`.
- `res_valid` with an empty queue, and again during FLUSH:
  - `err_unmatched` pulses each time.
  - Counters and `upd_valid` are unchanged.
- CNT_W=3: resolve 9 all-wrong branches, re-pushing after each FLUSH:
  - `total_cnt` and `miss_cnt` both saturate at 7.
- Assert `rst` for one cycle mid-FLUSH with the queue non-empty:
  - Every output returns to its reset value on that edge.
  - `pred_ready=1` the cycle after `rst` drops.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Bus between the branch predictor, the execute-stage branch unit and the
// branch resolver: prediction issue, outcome resolution, predictor update and
// accuracy/status outputs.
interface branch_resolver_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int PW = $clog2(DEPTH + 1);

    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             upd_valid;
    logic             upd_taken;
    logic             mispredict;
    logic             flush;
    logic             err_unmatched;
    logic [PW-1:0]    pending;
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] miss_cnt;

    // Resolver side
    modport slave (
        input  pred_valid, pred_taken, res_valid, res_taken,
        output pred_ready, upd_valid, upd_taken, mispredict, flush,
               err_unmatched, pending, total_cnt, miss_cnt
    );

    // Predictor / branch-unit side
    modport master (
        output pred_valid, pred_taken, res_valid, res_taken,
        input  pred_ready, upd_valid, upd_taken, mispredict, flush,
               err_unmatched, pending, total_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: queues issued predictions in order, matches the oldest one
// against each resolved outcome, drives the predictor update, flushes the
// wrong-path predictions after a mispredict and keeps saturating accuracy
// counters.
module branch_resolver #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolver_if.slave bus
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [PW-1:0] FULL_LVL   = PW'(DEPTH);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [FW-1:0]    r_fcnt;
    logic [FW-1:0]    w_fcnt_nxt;
    logic             r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_pending;
    logic [PW-1:0]    w_pending_nxt;
    logic             r_upd_valid;
    logic             r_upd_taken;
    logic             r_mispredict;
    logic             r_err_unmatched;
    logic [CNT_W-1:0] r_total_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    logic w_pred_ready;
    logic w_push;
    logic w_pop;
    logic w_head;
    logic w_miss;
    logic w_unmatched;

    // Only the oldest entry is ever compared, so a freshly written tail entry
    // cannot be popped in the cycle it is pushed (pending is still 0 for it).
    assign w_pred_ready = !rst && (r_state == ST_RUN) && (r_pending < FULL_LVL);
    assign w_push       = bus.pred_valid && w_pred_ready;
    assign w_pop        = bus.res_valid && (r_pending != PW'(0));
    assign w_head       = r_mem[r_rd_ptr];
    assign w_miss       = w_pop && (w_head != bus.res_taken);
    assign w_unmatched  = bus.res_valid && (r_pending == PW'(0));

    // FSM next state: a mispredicting pop starts the flush window, the
    // down-counter ends it.
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            ST_RUN: begin
                if (w_miss) begin
                    w_state_nxt = ST_FLUSH;
                    w_fcnt_nxt  = FLUSH_LOAD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (r_fcnt == FW'(0)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_fcnt_nxt = r_fcnt - FW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_fcnt_nxt  = FW'(0);
            end
        endcase
    end

    // FSM state and flush down-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_fcnt  <= FW'(0);
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Occupancy: a mispredict empties the queue and swallows a same-cycle push.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_miss) begin
            w_pending_nxt = PW'(0);
        end else if (w_push && !w_pop) begin
            w_pending_nxt = r_pending + PW'(1);
        end else if (!w_push && w_pop) begin
            w_pending_nxt = r_pending - PW'(1);
        end else begin
            w_pending_nxt = r_pending;
        end
    end

    // Prediction storage; validity is governed entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.pred_taken;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= AW'(0);
            r_rd_ptr  <= AW'(0);
            r_pending <= PW'(0);
        end else if (w_miss) begin
            r_wr_ptr  <= AW'(0);
            r_rd_ptr  <= AW'(0);
            r_pending <= PW'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_pending <= w_pending_nxt;
        end
    end

    // Registered predictor update, mispredict/error pulses and accuracy counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_valid     <= 1'b0;
            r_upd_taken     <= 1'b0;
            r_mispredict    <= 1'b0;
            r_err_unmatched <= 1'b0;
            r_total_cnt     <= CNT_W'(0);
            r_miss_cnt      <= CNT_W'(0);
        end else begin
            r_upd_valid     <= w_pop;
            r_upd_taken     <= w_pop ? bus.res_taken : 1'b0;
            r_mispredict    <= w_miss;
            r_err_unmatched <= w_unmatched;
            if (w_pop) begin
                r_total_cnt <= sat_inc(r_total_cnt);
            end
            if (w_miss) begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end
        end
    end

    assign bus.pred_ready    = w_pred_ready;
    assign bus.upd_valid     = r_upd_valid;
    assign bus.upd_taken     = r_upd_taken;
    assign bus.mispredict    = r_mispredict;
    assign bus.flush         = (r_state == ST_FLUSH);
    assign bus.err_unmatched = r_err_unmatched;
    assign bus.pending       = r_pending;
    assign bus.total_cnt     = r_total_cnt;
    assign bus.miss_cnt      = r_miss_cnt;
endmodule
